// File: rtl/ram_sync_bhw.sv
// ram_sync_bhw: clocked big-endian byte/halfword/word data RAM with a
// programmable wait-state counter, enable/moc handshake and sign extension.
// Optional alignment fault detection is compiled in with `define ALIGN_CHECK_EN.
module ram_sync_bhw #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  w_r,
  input  logic [1:0]            access_mode,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  moc,
  output logic                  busy,
  output logic                  fault
);

  localparam int         DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t state, state_nx;
  logic [3:0] cnt;

  logic [ADDR_WIDTH-1:0] a_q;
  logic [1:0]            mode_q;
  logic                  rd_q;
  logic                  sx_q;
  logic [31:0]           d_q;

  logic [7:0] mem [DEPTH];

  // With WAIT_STATES = 0 the commit edge is the request edge itself, so the
  // access must use the live inputs rather than the latched copies.
  logic [ADDR_WIDTH-1:0] a_r;
  logic [1:0]            mode_r;
  logic                  rd_r;
  logic                  sx_r;
  logic [31:0]           d_r;
  logic                  commit;
  logic                  mis_r;
  logic [7:0]            b0, b1, b2, b3;
  logic [31:0]           rd_val;

  assign a_r    = (state == IDLE) ? address     : a_q;
  assign mode_r = (state == IDLE) ? access_mode : mode_q;
  assign rd_r   = (state == IDLE) ? w_r         : rd_q;
  assign sx_r   = (state == IDLE) ? sign_ext    : sx_q;
  assign d_r    = (state == IDLE) ? data_in     : d_q;

  assign commit = (state_nx == DONE) && (state != DONE);

`ifdef ALIGN_CHECK_EN
  assign mis_r = ((mode_r == 2'b01) && a_r[0]) ||
                 ((mode_r == 2'b10) && (a_r[1:0] != 2'b00));
`else
  assign mis_r = 1'b0;
`endif

  // Address wrap modulo DEPTH falls out of the ADDR_WIDTH-bit addition.
  assign b0 = mem[a_r];
  assign b1 = mem[a_r + ADDR_WIDTH'(1)];
  assign b2 = mem[a_r + ADDR_WIDTH'(2)];
  assign b3 = mem[a_r + ADDR_WIDTH'(3)];

  // Big-endian read assembly with optional sign extension of narrow reads
  always_comb begin
    rd_val = '0;
    case (mode_r)
      2'b10:   rd_val = {b0, b1, b2, b3};
      2'b01:   rd_val = {{16{sx_r & b0[7]}}, b0, b1};
      default: rd_val = {{24{sx_r & b0[7]}}, b0};
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = (WS == 4'd0) ? DONE : WAIT;
      WAIT:    if (cnt == 4'd1) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Wait counter and request latches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      a_q    <= '0;
      mode_q <= '0;
      rd_q   <= 1'b0;
      sx_q   <= 1'b0;
      d_q    <= '0;
    end else if (state == IDLE) begin
      if (enable) begin
        cnt    <= WS;
        a_q    <= address;
        mode_q <= access_mode;
        rd_q   <= w_r;
        sx_q   <= sign_ext;
        d_q    <= data_in;
      end
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Read data and fault flag, updated only at the commit edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
      fault    <= 1'b0;
    end else begin
      fault <= commit & mis_r;
      if (commit && rd_r && !mis_r) data_out <= rd_val;
    end
  end

  // Storage writes; contents survive reset, and no write commits while reset is held
  always_ff @(posedge clk) begin
    if (reset_n && commit && !rd_r && !mis_r) begin
      case (mode_r)
        2'b10: begin
          mem[a_r]                  <= d_r[31:24];
          mem[a_r + ADDR_WIDTH'(1)] <= d_r[23:16];
          mem[a_r + ADDR_WIDTH'(2)] <= d_r[15:8];
          mem[a_r + ADDR_WIDTH'(3)] <= d_r[7:0];
        end
        2'b01: begin
          mem[a_r]                  <= d_r[15:8];
          mem[a_r + ADDR_WIDTH'(1)] <= d_r[7:0];
        end
        default: mem[a_r] <= d_r[7:0];
      endcase
    end
  end

  assign moc  = (state == DONE);
  assign busy = (state != IDLE);

endmodule
